// File: rtl/button_event_if.sv
// rtl/button_event_if.sv - level inputs and event/held outputs for button_event
interface button_event_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn_level;
  logic               repeat_en;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] release_ev;
  logic [NUM_BTN-1:0] long_press;
  logic [NUM_BTN-1:0] repeat_ev;
  logic [NUM_BTN-1:0] held;

  modport master (
    output btn_level, repeat_en,
    input  press, release_ev, long_press, repeat_ev, held
  );

  modport slave (
    input  btn_level, repeat_en,
    output press, release_ev, long_press, repeat_ev, held
  );
endinterface

// File: rtl/button_event.sv
// rtl/button_event.sv - per-channel press/release/long-press/repeat pulse generator
// Each channel runs an IDLE/PRESS/HELD FSM with one shared-purpose counter; all outputs registered.
module button_event #(
  parameter int NUM_BTN       = 4,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input logic          Clk,
  input logic          Reset,
  button_event_if.slave bus
);
  localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_HELD} state_t;

  state_t        state_q [NUM_BTN];
  state_t        state_d [NUM_BTN];
  logic [CW-1:0] cnt_q   [NUM_BTN];
  logic [CW-1:0] cnt_d   [NUM_BTN];

  logic [NUM_BTN-1:0] press_q, release_q, long_q, repeat_q, held_q;
  logic [NUM_BTN-1:0] press_d, release_d, long_d, repeat_d, held_d;

  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      press_d[i]   = 1'b0;
      release_d[i] = 1'b0;
      long_d[i]    = 1'b0;
      repeat_d[i]  = 1'b0;
      case (state_q[i])
        ST_IDLE: begin
          if (bus.btn_level[i]) begin
            state_d[i] = ST_PRESS;
            cnt_d[i]   = '0;
            press_d[i] = 1'b1;
          end
        end
        ST_PRESS: begin
          if (!bus.btn_level[i]) begin
            state_d[i]   = ST_IDLE;
            cnt_d[i]     = '0;
            release_d[i] = 1'b1;
          end else if (cnt_q[i] == LONG_LAST) begin
            state_d[i] = ST_HELD;
            cnt_d[i]   = '0;
            long_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        ST_HELD: begin
          // Repeat phase keeps counting even while repeat_en is low.
          if (!bus.btn_level[i]) begin
            state_d[i]   = ST_IDLE;
            cnt_d[i]     = '0;
            release_d[i] = 1'b1;
          end else if (cnt_q[i] == REPEAT_LAST) begin
            cnt_d[i]    = '0;
            repeat_d[i] = bus.repeat_en;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      held_d[i] = (state_d[i] == ST_HELD);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      repeat_q  <= '0;
      held_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign bus.press      = press_q;
  assign bus.release_ev = release_q;
  assign bus.long_press = long_q;
  assign bus.repeat_ev  = repeat_q;
  assign bus.held       = held_q;
endmodule

// File: tb/tb_button_event.sv
// tb/tb_button_event.sv - directed edge-by-edge checks of button_event
module tb_button_event;
  logic Clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;
  int   e     = 0;

  always #5 Clk = ~Clk;

  button_event_if #(.NUM_BTN(4)) bus_a ();
  button_event_if #(.NUM_BTN(1)) bus_b ();

  button_event #(.NUM_BTN(4), .LONG_CYCLES(8), .REPEAT_CYCLES(4)) dut_a (
    .Clk(Clk), .Reset(Reset), .bus(bus_a.slave)
  );

  button_event #(.NUM_BTN(1), .LONG_CYCLES(2), .REPEAT_CYCLES(1)) dut_b (
    .Clk(Clk), .Reset(Reset), .bus(bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, e, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic in_rng(input int x, input int lo, input int hi);
    return (x >= lo) && (x <= hi);
  endfunction

  task automatic check_a(input string ph, input logic [3:0] p, input logic [3:0] r,
                         input logic [3:0] l, input logic [3:0] rp, input logic [3:0] h);
    check({ph, ".press"},   32'(bus_a.press),      32'(p));
    check({ph, ".release"}, 32'(bus_a.release_ev), 32'(r));
    check({ph, ".long"},    32'(bus_a.long_press), 32'(l));
    check({ph, ".repeat"},  32'(bus_a.repeat_ev),  32'(rp));
    check({ph, ".held"},    32'(bus_a.held),       32'(h));
  endtask

  task automatic check_b(input string ph, input logic p, input logic r,
                         input logic l, input logic rp, input logic h);
    check({ph, ".press"},   32'(bus_b.press),      32'(p));
    check({ph, ".release"}, 32'(bus_b.release_ev), 32'(r));
    check({ph, ".long"},    32'(bus_b.long_press), 32'(l));
    check({ph, ".repeat"},  32'(bus_b.repeat_ev),  32'(rp));
    check({ph, ".held"},    32'(bus_b.held),       32'(h));
  endtask

  initial begin
    Reset           = 1'b1;
    bus_a.btn_level = '0;
    bus_a.repeat_en = 1'b1;
    bus_b.btn_level = '0;
    bus_b.repeat_en = 1'b1;
    tick();
    tick();
    check_a("rst", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    check_b("rst_b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;

    // ch0 taps twice (release/press back to back), ch1 long hold, ch2 threshold race
    for (int k = 1; k <= 40; k++) begin
      bus_a.btn_level = {1'b0, in_rng(k, 10, 17), in_rng(k, 10, 29),
                         in_rng(k, 10, 12) || in_rng(k, 14, 15)};
      bus_b.btn_level = in_rng(k, 10, 16);
      e = k;
      tick();
      check_a("p1",
              {1'b0, k == 10, k == 10, (k == 10) || (k == 14)},
              {1'b0, k == 18, k == 30, (k == 13) || (k == 16)},
              {2'b00, k == 18, 1'b0},
              {2'b00, (k == 22) || (k == 26), 1'b0},
              {2'b00, in_rng(k, 18, 29), 1'b0});
      check_b("p1b", k == 10, k == 17, k == 12, in_rng(k, 13, 16), in_rng(k, 12, 16));
    end

    Reset           = 1'b1;
    bus_a.btn_level = '0;
    bus_b.btn_level = '0;
    tick();
    Reset = 1'b0;

    // repeat_en low on edges 20..24; ch1 pressed at 10, ch3 pressed at 5
    for (int k = 1; k <= 42; k++) begin
      bus_a.btn_level = {k >= 5, 1'b0, in_rng(k, 10, 35), 1'b0};
      bus_a.repeat_en = !in_rng(k, 20, 24);
      e = 100 + k;
      tick();
      check_a("p2",
              {k == 5, 1'b0, k == 10, 1'b0},
              {2'b00, k == 36, 1'b0},
              {k == 13, 1'b0, k == 18, 1'b0},
              {(k == 17) || (k == 25) || (k == 29) || (k == 33) || (k == 37) || (k == 41),
               1'b0, (k == 26) || (k == 30) || (k == 34), 1'b0},
              {k >= 13, 1'b0, in_rng(k, 18, 35), 1'b0});
      check_b("p2b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset between edges with ch3 held: immediate clear, no release pulse
    bus_a.repeat_en = 1'b1;
    #2;
    Reset = 1'b1;
    #1;
    e = 200;
    check_a("rst_mid", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    e = 201;
    check_a("rst_hold", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    e = 202;
    check_a("rst_hold", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    Reset = 1'b0;

    for (int f = 1; f <= 10; f++) begin
      e = 300 + f;
      tick();
      check_a("p3", {f == 1, 3'b000}, 4'h0, {f == 9, 3'b000}, 4'h0, {f >= 9, 3'b000});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
